// File: rtl/ahb_manager_burst_checker.sv
// AHB-Lite manager that writes an incrementing burst, reads it back and counts
// read-back mismatches plus ERROR responses, repeated for NumRounds rounds.
module ahb_manager_burst_checker #(
  parameter int                      AddressWidth = 32,
  parameter int                      DataWidth    = 32,
  parameter logic [AddressWidth-1:0] BaseAddress  = '0,
  parameter int                      NumBeats     = 4,
  parameter int                      NumRounds    = 1,
  parameter logic [31:0]             Seed         = 32'hA5A5_0000
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    start,
  input  logic                    HREADY,
  input  logic                    HRESP,
  input  logic [DataWidth-1:0]    HRDATA,
  output logic [AddressWidth-1:0] HADDR,
  output logic                    HWRITE,
  output logic [DataWidth-1:0]    HWDATA,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [1:0]              HTRANS,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             error_count
);

  localparam logic [AddressWidth-1:0] BEAT_BYTES  = AddressWidth'(DataWidth / 8);
  localparam logic [AddressWidth-1:0] ROUND_BYTES = AddressWidth'(NumBeats * DataWidth / 8);
  localparam logic [4:0]              LAST_BEAT   = 5'(NumBeats - 1);
  localparam logic [7:0]              LAST_ROUND  = 8'(NumRounds - 1);
  localparam logic [1:0]              TR_IDLE     = 2'b00;
  localparam logic [1:0]              TR_NONSEQ   = 2'b10;
  localparam logic [1:0]              TR_SEQ      = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_LAST, S_RD_ADDR, S_RD_LAST, S_DONE
  } state_t;

  state_t                  state;
  logic [4:0]              beat;
  logic [7:0]              round;
  logic [AddressWidth-1:0] rnd_base;
  logic                    dphase;
  logic [AddressWidth-1:0] dph_addr;
  logic                    err_first;
  logic                    mismatch;

  assign HSIZE  = (DataWidth == 64) ? 3'd3 : 3'd2;
  assign HBURST = (NumBeats == 16) ? 3'b111 :
                  (NumBeats == 8)  ? 3'b101 :
                  (NumBeats == 4)  ? 3'b011 : 3'b000;

  // 64-bit beats carry the inverted pattern in the upper half
  function automatic logic [DataWidth-1:0] pattern(input logic [AddressWidth-1:0] addr);
    logic [31:0] lo;
    logic [63:0] both;
    lo   = 32'(addr) ^ Seed;
    both = {~lo, lo};
    return both[DataWidth-1:0];
  endfunction

  assign err_first = dphase && HRESP && !HREADY;
  assign mismatch  = (state == S_RD_ADDR || state == S_RD_LAST) && dphase && HREADY &&
                     !HRESP && (HRDATA != pattern(dph_addr));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= S_IDLE;
      HTRANS      <= TR_IDLE;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HWDATA      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error_count <= '0;
      round       <= '0;
      beat        <= '0;
      rnd_base    <= '0;
      dphase      <= 1'b0;
      dph_addr    <= '0;
    end else begin
      // data phase follows every accepted NONSEQ/SEQ address phase
      if (HREADY) begin
        dphase   <= HTRANS[1];
        dph_addr <= HADDR;
      end
      if ((err_first || mismatch) && error_count != 16'hFFFF)
        error_count <= error_count + 16'd1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_WR_ADDR;
            busy        <= 1'b1;
            done        <= 1'b0;
            error_count <= '0;
            round       <= '0;
            beat        <= '0;
            rnd_base    <= BaseAddress;
            HADDR       <= BaseAddress;
            HWRITE      <= 1'b1;
            HTRANS      <= TR_NONSEQ;
          end
        end
        S_WR_ADDR, S_RD_ADDR: begin
          if (err_first) begin
            // cancel the rest of the burst; the *_LAST state absorbs the second response cycle
            HTRANS <= TR_IDLE;
            state  <= (state == S_WR_ADDR) ? S_WR_LAST : S_RD_LAST;
          end else if (HREADY) begin
            if (state == S_WR_ADDR) HWDATA <= pattern(HADDR);
            if (beat == LAST_BEAT) begin
              HTRANS <= TR_IDLE;
              state  <= (state == S_WR_ADDR) ? S_WR_LAST : S_RD_LAST;
            end else begin
              HADDR  <= HADDR + BEAT_BYTES;
              HTRANS <= TR_SEQ;
              beat   <= beat + 5'd1;
            end
          end
        end
        S_WR_LAST: begin
          if (HREADY) begin
            state  <= S_RD_ADDR;
            HADDR  <= rnd_base;
            HWRITE <= 1'b0;
            HTRANS <= TR_NONSEQ;
            beat   <= '0;
          end
        end
        S_RD_LAST: begin
          if (HREADY) begin
            rnd_base <= rnd_base + ROUND_BYTES;
            if (round == LAST_ROUND) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state  <= S_WR_ADDR;
              round  <= round + 8'd1;
              HADDR  <= rnd_base + ROUND_BYTES;
              HWRITE <= 1'b1;
              HTRANS <= TR_NONSEQ;
              beat   <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_manager_burst_checker.sv
// Bench: expected bus transfers are queued per test; monitors pop and compare
// every accepted address phase and write data phase against the queue.
module tb_ahb_manager_burst_checker;

  localparam logic [1:0] NS = 2'b10, SQ = 2'b11;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  trans;
    logic [63:0] wd;
  } xfer_t;

  logic        HCLK = 1'b0, HRESET = 1'b1, start = 1'b0, start64 = 1'b0;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  logic [31:0] HRDATA = '0;
  logic [63:0] HRDATA64 = '0;
  logic [31:0] HADDR, HADDR64, HWDATA;
  logic [63:0] HWDATA64;
  logic        HWRITE, HWRITE64, busy, busy64, done, done64;
  logic [2:0]  HSIZE, HBURST, HSIZE64, HBURST64;
  logic [1:0]  HTRANS, HTRANS64;
  logic [15:0] error_count, error_count64;

  int nchk = 0, nfail = 0;
  xfer_t q32[$], q64[$];
  logic [31:0] mem [logic [31:0]];

  // memory-model knobs
  int          stall_left = 0;
  logic [31:0] stall_addr = '0, err_addr = '0, corrupt_addr = '0;
  logic        err_arm = 1'b0, corrupt_en = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_manager_burst_checker u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA), .HSIZE(HSIZE),
    .HBURST(HBURST), .HTRANS(HTRANS), .busy(busy), .done(done), .error_count(error_count)
  );

  ahb_manager_burst_checker #(
    .DataWidth(64), .NumBeats(8), .NumRounds(2), .BaseAddress(32'hFFFF_FF80)
  ) u_dut64 (
    .HCLK(HCLK), .HRESET(HRESET), .start(start64), .HREADY(1'b1), .HRESP(1'b0),
    .HRDATA(HRDATA64), .HADDR(HADDR64), .HWRITE(HWRITE64), .HWDATA(HWDATA64), .HSIZE(HSIZE64),
    .HBURST(HBURST64), .HTRANS(HTRANS64), .busy(busy64), .done(done64), .error_count(error_count64)
  );

  function automatic logic [31:0] pat32(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [63:0] pat64(input logic [31:0] a);
    logic [31:0] lo;
    lo = a ^ 32'hA5A5_0000;
    return {~lo, lo};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push32(input logic [31:0] a, input logic wr, input logic [1:0] tr);
    xfer_t e;
    e.addr = a; e.wr = wr; e.trans = tr; e.wd = {32'h0, pat32(a)};
    q32.push_back(e);
  endtask

  task automatic push_burst32(input logic [31:0] base, input int n, input logic wr);
    for (int i = 0; i < n; i++) push32(base + 32'(4 * i), wr, (i == 0) ? NS : SQ);
  endtask

  task automatic push_burst64(input logic [31:0] base, input int n, input logic wr);
    xfer_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = base + 32'(8 * i); e.wr = wr; e.trans = (i == 0) ? NS : SQ; e.wd = pat64(e.addr);
      q64.push_back(e);
    end
  endtask

  // Pulse start, then watch until done; optional hold-window probe and a
  // start pulse while busy (poke) that must be ignored.
  task automatic run32(input int exp_done, input int exp_err, input int plo, input int phi,
                       input logic [31:0] pa, input logic [1:0] pt, input logic [31:0] pd,
                       input int poke);
    int dc;
    dc = -1;
    @(posedge HCLK); #1 start = 1'b1;
    @(posedge HCLK); #1 start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      @(negedge HCLK);
      start = (c == poke);
      if (c >= plo && c <= phi) begin
        chk("hold_haddr", HADDR, pa);
        chk("hold_htrans", HTRANS, pt);
        chk("hold_hwdata", HWDATA, pd);
      end
      if (done) begin dc = c; break; end
    end
    start = 1'b0;
    chk("done_cycle", dc, exp_done);
    chk("error_count", error_count, exp_err);
    chk("busy_at_done", busy, 0);
    chk("queue_drained", q32.size(), 0);
  endtask

  // Subordinate for the 32-bit DUT: drives response for the current data phase just after the edge.
  initial begin : mem_model
    logic da, dwr;
    logic [31:0] dad;
    int es;
    da = 1'b0; dwr = 1'b0; dad = '0; es = 0;
    forever begin
      @(posedge HCLK); #1;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      if (da) begin
        if (err_arm && dwr && dad == err_addr) begin
          HREADY = 1'b0; HRESP = 1'b1; err_arm = 1'b0; es = 1;
        end else if (es == 1) begin
          HRESP = 1'b1; es = 0;
        end else if (dwr && dad == stall_addr && stall_left > 0) begin
          HREADY = 1'b0; stall_left--;
        end else if (!dwr) begin
          HRDATA = (corrupt_en && dad == corrupt_addr) ? 32'h0 :
                   (mem.exists(dad) ? mem[dad] : 32'h0);
        end
      end
      @(negedge HCLK);
      if (da && HREADY && dwr && !HRESP) mem[dad] = HWDATA;
      if (HREADY) begin da = HTRANS[1]; dad = HADDR; dwr = HWRITE; end
      if (HRESET) da = 1'b0;
    end
  end

  // Zero-wait subordinate for the 64-bit DUT returns the expected pattern.
  initial begin : mem_model64
    logic [31:0] a;
    forever begin
      @(negedge HCLK); a = HADDR64;
      @(posedge HCLK); #1 HRDATA64 = pat64(a);
    end
  end

  initial begin : mon32
    xfer_t e;
    logic dv, dw;
    logic [31:0] dd;
    dv = 1'b0; dw = 1'b0; dd = '0;
    forever begin
      @(negedge HCLK);
      if (dv && HREADY) begin
        if (dw) chk("hwdata", HWDATA, dd);
        dv = 1'b0;
      end
      if (HTRANS[1] === 1'b1 && HREADY) begin
        if (q32.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL unexpected_xfer: actual HADDR %0h required no transfer", HADDR);
        end else begin
          e = q32.pop_front();
          chk("haddr", HADDR, e.addr);
          chk("htrans", HTRANS, e.trans);
          chk("hwrite", HWRITE, e.wr);
          dv = 1'b1; dw = e.wr; dd = e.wd[31:0];
        end
      end
      if (HRESET) dv = 1'b0;
    end
  end

  initial begin : mon64
    xfer_t e;
    logic dv;
    logic [63:0] dd;
    dv = 1'b0; dd = '0;
    forever begin
      @(negedge HCLK);
      if (dv) chk("hwdata64", HWDATA64, dd);
      dv = 1'b0;
      if (HTRANS64[1] === 1'b1) begin
        if (q64.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL unexpected_xfer64: actual HADDR %0h required no transfer", HADDR64);
        end else begin
          e = q64.pop_front();
          chk("haddr64", HADDR64, e.addr);
          chk("htrans64", HTRANS64, e.trans);
          chk("hwrite64", HWRITE64, e.wr);
          dv = e.wr; dd = e.wd;
        end
      end
    end
  end

  initial begin : main
    int dc;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", HWRITE, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error_count", error_count, 0);
    chk("hsize32", HSIZE, 3'd2);
    chk("hburst32", HBURST, 3'b011);
    chk("hsize64", HSIZE64, 3'd3);
    chk("hburst64", HBURST64, 3'b101);
    @(posedge HCLK); #1 HRESET = 1'b0;

    // zero-wait round, with a start pulse while busy that must be ignored
    push_burst32(0, 4, 1); push_burst32(0, 4, 0);
    run32(11, 0, 1, 0, 0, 0, 0, 5);

    // two wait states on beat 1's data phase while beat 2's address is pending
    stall_addr = 32'h4; stall_left = 2;
    push_burst32(0, 4, 1); push_burst32(0, 4, 0);
    run32(13, 0, 3, 4, 32'h8, SQ, 32'hA5A5_0004, -1);

    // corrupted read-back at 0x4
    corrupt_en = 1'b1; corrupt_addr = 32'h4;
    push_burst32(0, 4, 1); push_burst32(0, 4, 0);
    run32(11, 1, 1, 0, 0, 0, 0, -1);
    corrupt_en = 1'b0;

    // two-cycle ERROR on write beat 1 cancels the rest of the write burst
    err_addr = 32'h4; err_arm = 1'b1;
    push32(0, 1, NS); push32(32'h4, 1, SQ); push_burst32(0, 4, 0);
    run32(10, 1, 4, 4, 32'h8, 2'b00, 32'hA5A5_0004, -1);

    // reset during read beat 2 after a mismatch has been counted
    corrupt_en = 1'b1; corrupt_addr = 32'h0;
    push_burst32(0, 4, 1); push_burst32(0, 3, 0);
    @(posedge HCLK); #1 start = 1'b1;
    @(posedge HCLK); #1 start = 1'b0;
    repeat (7) @(posedge HCLK);
    #1 HRESET = 1'b1;
    @(negedge HCLK);
    chk("pre_rst_error_count", error_count, 1);
    chk("pre_rst_haddr", HADDR, 32'h8);
    @(posedge HCLK); #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("post_rst_htrans", HTRANS, 2'b00);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_error_count", error_count, 0);
    chk("post_rst_queue", q32.size(), 0);
    corrupt_en = 1'b0;

    // full rerun after reset
    push_burst32(0, 4, 1); push_burst32(0, 4, 0);
    run32(11, 0, 1, 0, 0, 0, 0, -1);

    // 64-bit, 8 beats, 2 rounds near the top of the address space
    push_burst64(32'hFFFF_FF80, 8, 1); push_burst64(32'hFFFF_FF80, 8, 0);
    push_burst64(32'hFFFF_FFC0, 8, 1); push_burst64(32'hFFFF_FFC0, 8, 0);
    @(posedge HCLK); #1 start64 = 1'b1;
    @(posedge HCLK); #1 start64 = 1'b0;
    dc = -1;
    for (int c = 1; c < 200; c++) begin
      @(negedge HCLK);
      if (done64) begin dc = c; break; end
    end
    chk("done_cycle64", dc, 37);
    chk("error_count64", error_count64, 0);
    chk("busy64_at_done", busy64, 0);
    chk("queue64_drained", q64.size(), 0);

    repeat (2) @(posedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
